// File: rtl/timer_pkg.sv
// Shared timer constants: counter width/limits, count direction and clock-select encodings.
package timer_pkg;

   localparam int unsigned CNT_W   = 16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Prescaler selection used by the upstream clock-select stage.
   typedef enum logic [2:0] {
      CLKSEL_DIV1   = 3'd0,
      CLKSEL_DIV2   = 3'd1,
      CLKSEL_DIV4   = 3'd2,
      CLKSEL_DIV8   = 3'd3,
      CLKSEL_DIV16  = 3'd4,
      CLKSEL_DIV64  = 3'd5,
      CLKSEL_DIV256 = 3'd6,
      CLKSEL_EXT    = 3'd7
   } clk_sel_e;

endpackage

// File: rtl/timer_counter_if.sv
// Control/status bundle between the timer register block (master) and the counting stage (slave).
interface timer_counter_if #(
   parameter int unsigned WIDTH = 16
);
   logic             clk_in;
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] tdr;
   logic             ovf_clr;
   logic             udf_clr;
   logic [WIDTH-1:0] cnt;
   logic             ovf;
   logic             udf;

   modport master (
      output clk_in, en, up_dn, load, tdr, ovf_clr, udf_clr,
      input  cnt, ovf, udf
   );

   modport slave (
      input  clk_in, en, up_dn, load, tdr, ovf_clr, udf_clr,
      output cnt, ovf, udf
   );
endinterface

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector for a signal already synchronous to i_clk.
module rise_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_d;

   // Tracks unconditionally so a level already high at enable time never looks like an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sig_d <= 1'b0;
      else          r_sig_d <= i_sig;
   end

   assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/timer_counter.sv
// Up/down timer counter with load and sticky ovf/udf flags, clocked by pclk.
// Optional macro TIMER_AUTO_RELOAD_EN: reload from tdr on wrap instead of modulo wrap.
module timer_counter
   import timer_pkg::*;
#(
   parameter int unsigned      WIDTH   = CNT_W,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic              pclk,
   input logic              rst_n,
   timer_counter_if.slave   bus
);

   logic             w_tick;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic [WIDTH-1:0] w_wrap_up;
   logic [WIDTH-1:0] w_wrap_dn;
   logic             w_ovf_set;
   logic             w_udf_set;
   logic [WIDTH-1:0] r_cnt;
   logic             r_ovf;
   logic             r_udf;

   rise_detect u_rise_detect (
      .i_clk   (pclk),
      .i_rst_n (rst_n),
      .i_sig   (bus.clk_in),
      .o_rise  (w_tick)
   );

`ifdef TIMER_AUTO_RELOAD_EN
   assign w_wrap_up = bus.tdr;
   assign w_wrap_dn = bus.tdr;
`else
   assign w_wrap_up = '0;
   assign w_wrap_dn = '1;
`endif

   // Load beats a coincident tick and suppresses its flag.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_set = 1'b0;
      w_udf_set = 1'b0;
      if (bus.load) begin
         w_cnt_nxt = bus.tdr;
      end else if (bus.en && w_tick) begin
         if (bus.up_dn == DIR_UP) begin
            if (r_cnt == '1) begin
               w_cnt_nxt = w_wrap_up;
               w_ovf_set = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end else begin
            if (r_cnt == '0) begin
               w_cnt_nxt = w_wrap_dn;
               w_udf_set = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= RST_VAL;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ovf <= w_ovf_set | (r_ovf & ~bus.ovf_clr);
         r_udf <= w_udf_set | (r_udf & ~bus.udf_clr);
      end
   end

   assign bus.cnt = r_cnt;
   assign bus.ovf = r_ovf;
   assign bus.udf = r_udf;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with a per-cycle arithmetic reference model.
module tb_timer_counter;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic pclk  = 1'b0;
   logic rst_n = 1'b1;

   int checks = 0;
   int errors = 0;

   timer_counter_if #(.WIDTH(16)) bus ();

   timer_counter #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
      .pclk  (pclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 pclk = ~pclk;

   // Reference model: plain integer arithmetic on the counting rules.
   int m_cnt  = 0;
   bit m_ovf  = 1'b0;
   bit m_udf  = 1'b0;
   bit m_prev = 1'b0;

   always @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  = 0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_prev = 1'b0;
      end else begin
         bit tick, os, us;
         int n;
         tick   = bus.clk_in && !m_prev;
         m_prev = bus.clk_in;
         os = 1'b0;
         us = 1'b0;
         if (bus.load) begin
            m_cnt = int'(bus.tdr);
         end else if (bus.en && tick) begin
            n = bus.up_dn ? m_cnt - 1 : m_cnt + 1;
            if (n > 65535) begin
               m_cnt = AR ? int'(bus.tdr) : 0;
               os = 1'b1;
            end else if (n < 0) begin
               m_cnt = AR ? int'(bus.tdr) : 65535;
               us = 1'b1;
            end else begin
               m_cnt = n;
            end
         end
         m_ovf = os | (m_ovf & !bus.ovf_clr);
         m_udf = us | (m_udf & !bus.udf_clr);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge pclk) begin
      if (rst_n) begin
         chk("cnt", int'(bus.cnt), m_cnt);
         chk("ovf", int'(bus.ovf), int'(m_ovf));
         chk("udf", int'(bus.udf), int'(m_udf));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // One clk_in period of pclk/4: high two cycles, low two cycles.
   task automatic period();
      bus.clk_in = 1'b1; cyc(2);
      bus.clk_in = 1'b0; cyc(2);
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.tdr = v; bus.load = 1'b1; cyc(1);
      bus.load = 1'b0;
   endtask

   initial begin
      bus.clk_in = 1'b0; bus.en = 1'b0; bus.up_dn = 1'b0; bus.load = 1'b0;
      bus.tdr = '0; bus.ovf_clr = 1'b0; bus.udf_clr = 1'b0;
      #1 rst_n = 1'b0;
      #22 rst_n = 1'b1;
      cyc(1);
      chk("reset_cnt", int'(bus.cnt), 0);
      chk("reset_flags", int'({bus.ovf, bus.udf}), 0);

      repeat (3) period();
      chk("idle_cnt", int'(bus.cnt), 0);

      bus.en = 1'b1;
      bus.clk_in = 1'b1; cyc(1);
      chk("first_step", int'(bus.cnt), 1);
      cyc(1); bus.clk_in = 1'b0; cyc(2);
      chk("one_per_period", int'(bus.cnt), 1);
      repeat (4) period();
      chk("up5", int'(bus.cnt), 5);

      do_load(16'hFFFE);
      chk("load_fffe", int'(bus.cnt), 16'hFFFE);
      bus.tdr = 16'h1234;
      period();
      chk("up_ffff", int'(bus.cnt), 16'hFFFF);
      bus.clk_in = 1'b1; cyc(1);
      chk("wrap_cnt", int'(bus.cnt), AR ? 16'h1234 : 0);
      chk("wrap_ovf", int'(bus.ovf), 1);
      cyc(1); bus.clk_in = 1'b0; cyc(2);
      bus.ovf_clr = 1'b1; cyc(1); bus.ovf_clr = 1'b0;
      chk("ovf_clr", int'(bus.ovf), 0);

      do_load(16'hFFFF);
      bus.clk_in = 1'b1; bus.ovf_clr = 1'b1; cyc(1); bus.ovf_clr = 1'b0;
      chk("set_beats_clr", int'(bus.ovf), 1);
      cyc(1); bus.clk_in = 1'b0; cyc(2);

      do_load(16'h0001);
      bus.up_dn = 1'b1;
      period();
      chk("down_zero", int'(bus.cnt), 0);
      period();
      chk("underflow_cnt", int'(bus.cnt), AR ? 16'h0001 : 16'hFFFF);
      chk("udf_set", int'(bus.udf), 1);
      chk("ovf_kept", int'(bus.ovf), 1);
      bus.ovf_clr = 1'b1; bus.udf_clr = 1'b1; cyc(1);
      bus.ovf_clr = 1'b0; bus.udf_clr = 1'b0;
      chk("both_clr", int'({bus.ovf, bus.udf}), 0);

      bus.up_dn = 1'b0;
      bus.tdr = 16'h00A0; bus.load = 1'b1; bus.clk_in = 1'b1; cyc(1);
      bus.load = 1'b0;
      chk("load_vs_tick", int'(bus.cnt), 16'h00A0);
      cyc(1); bus.clk_in = 1'b0; cyc(2);
      chk("load_no_extra", int'(bus.cnt), 16'h00A0);

      bus.en = 1'b0;
      bus.clk_in = 1'b1; cyc(1);
      bus.en = 1'b1; cyc(2);
      chk("en_while_high", int'(bus.cnt), 16'h00A0);
      bus.clk_in = 1'b0; cyc(2);
      bus.clk_in = 1'b1; cyc(1);
      chk("en_next_edge", int'(bus.cnt), 16'h00A1);
      bus.clk_in = 1'b0; cyc(2);

      do_load(16'hFFFF);
      period();
      do_load(16'h0123);
      chk("pre_rst_cnt", int'(bus.cnt), 16'h0123);
      chk("pre_rst_ovf", int'(bus.ovf), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", int'(bus.cnt), 0);
      chk("async_rst_ovf", int'(bus.ovf), 0);
      @(posedge pclk); #2 rst_n = 1'b1;
      cyc(1);
      period(); period();
      chk("resume", int'(bus.cnt), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting stage directly downstream of the clock-select block in the 16-bit timer.
- Consumes the selected divided clock `clk_in`, which is generated in the `pclk` domain, and advances a 16-bit counter once per rising edge of `clk_in`.
- Supports up or down counting, parallel load from the data register, and sticky overflow/underflow flags for the register/interrupt logic.
- Clocked entirely by `pclk`; `clk_in` is sampled as data, never used as a clock.

Parameters:
- WIDTH, 16, counter and load-data width.
- RST_VAL, 16'h0000, counter value after reset.

Ports:
- pclk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_in  input  1  selected divided clock from the clock-select stage, synchronous to `pclk`.
- en  input  1  count enable; 1 = count on `clk_in` rising edges.
- up_dn  input  1  direction: 0 = up, 1 = down.
- load  input  1  synchronous load strobe.
- tdr  input  WIDTH  load / reload data.
- ovf_clr  input  1  clears `ovf`.
- udf_clr  input  1  clears `udf`.
- cnt  output  WIDTH  current count.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.

Behaviour:
- Reset (rst_n = 0, asynchronous, any time including mid-count):
  - `cnt` = RST_VAL, `ovf` = 0, `udf` = 0, internal `clk_in_d` = 0.
  - First `pclk` edge after release behaves normally.
- Edge detect:
  - `clk_in_d` <= `clk_in` every `pclk` edge, regardless of `en`.
  - tick = `clk_in` & ~`clk_in_d`.
  - Because `clk_in_d` keeps tracking while `en` = 0, asserting `en` while `clk_in` is already high produces no false tick.
  - No synchronizer is needed, since `clk_in` is already in the `pclk` domain.
- Latency: `cnt` updates at the same `pclk` edge where tick is true, i.e. the first edge sampling `clk_in` = 1 after it sampled 0. At most one count per `clk_in` period.
- Priority, evaluated per `pclk` edge:
  1. `load` = 1: `cnt` <= `tdr`. Any tick in the same cycle is discarded, and no flag is set.
  2. else `en` = 1 and tick, up (`up_dn` = 0):
     - `cnt` == 2^WIDTH-1: `cnt` <= 0 (wrap) and `ovf` <= 1.
     - otherwise `cnt` <= `cnt` + 1.
  3. else `en` = 1 and tick, down (`up_dn` = 1):
     - `cnt` == 0: `cnt` <= 2^WIDTH-1 and `udf` <= 1.
     - otherwise `cnt` <= `cnt` - 1.
  4. else `cnt` holds.
- Arithmetic is modulo 2^WIDTH, unsigned.
- A change of `up_dn` takes effect at the next tick; no other side effect.
- Flags:
  - Sticky until their clear input is asserted.
  - If set and clear occur in the same cycle, set wins and the flag stays 1.
  - `ovf` and `udf` are independent.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined: on wrap the counter reloads from `tdr` instead of wrapping.
  - Up-count overflow: `cnt` <= `tdr`.
  - Down-count underflow: `cnt` <= `tdr`.
  - Flags are set exactly as in the base behaviour.
- Not defined: plain modulo wrap as described under Behaviour; `tdr` is used only on `load`.

Decomposition:
- Package `timer_pkg` holds:
  - `CNT_W` = 16 and `CNT_MAX` = 16'hFFFF.
  - Direction constants `DIR_UP` = 1'b0 and `DIR_DN` = 1'b1.
  - Clock-select encoding constants shared with the clock-select stage.
- One sub-module, `rise_detect`: holds the `clk_in_d` register and produces the one-`pclk` tick. The same sub-module is reusable for later capture/compare inputs.
- Counter, load mux and flag logic stay in `timer_counter`.

Test Plan:
- Reset/idle: rst_n low, then high; `clk_in` toggling with `en` = 0 -> `cnt` = 0, `ovf` = 0 and `udf` = 0 throughout; `cnt` never changes.
- Up count: `en` = 1, `up_dn` = 0, 5 `clk_in` rising edges with `clk_in` = `pclk`/4 -> `cnt` = 5; each increment lands on the `pclk` edge sampling `clk_in` rising; exactly one step per `clk_in` period.
- Overflow:
  - `load` with `tdr` = 16'hFFFE, then 2 ticks up -> `cnt` = 16'hFFFF then 16'h0000, and `ovf` = 1 on that edge.
  - Pulse `ovf_clr` -> `ovf` = 0.
  - With TIMER_AUTO_RELOAD_EN and `tdr` = 16'h1234 -> `cnt` = 16'h1234 after the wrap.
- Underflow: `load` 16'h0001, `up_dn` = 1, 2 ticks -> `cnt` = 0 then 16'hFFFF, `udf` = 1, `ovf` unchanged.
- Collisions:
  - `load` = 1 on the same cycle as a tick with `tdr` = 16'h00A0 -> `cnt` = 16'h00A0, no extra count.
  - `ovf_clr` asserted on the cycle the overflow occurs -> `ovf` = 1.
  - `en` raised while `clk_in` is high -> no count until the next rising edge.
- Mid-operation reset: `cnt` = 16'h0123, `ovf` = 1; assert rst_n low between `pclk` edges -> `cnt` = 0 and `ovf` = 0 immediately (asynchronous); counting resumes from 0 after release.
